// File: rtl/uart_pkg.sv
// Shared UART constants: data width, error counter width and default receive FIFO geometry.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int ERR_CNT_W   = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_AW     = $clog2(FIFO_DEPTH);
endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Byte storage for the receive FIFO: synchronous write, combinational (show-ahead) read, no reset.
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [UART_DATA_W-1:0] i_wd,
  input  logic [AW-1:0]          i_raddr,
  output logic [UART_DATA_W-1:0] o_rd
);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) mem_q[i_waddr] <= i_wd;
  end

  assign o_rd = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: push on i_rx_complete, show-ahead pop on i_rd_en, 1-cycle push-to-visible; a push
// while full (and not popping) is dropped and latched in o_overflow. UART_RX_FIFO_ERR_DROP_EN discards errored frames.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [UART_DATA_W-1:0] i_rx_d,
  input  logic                   i_rx_complete,
  input  logic                   i_rx_error,
  input  logic                   i_rd_en,
  input  logic                   i_clr_stat,
  output logic [UART_DATA_W-1:0] o_rd_d,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [AW:0]            o_count,
  output logic                   o_overflow,
  output logic [ERR_CNT_W-1:0]   o_err_cnt
);

  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic [AW:0]          count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic push_req, push, pop, ovf_evt, err_evt;

`ifdef UART_RX_FIFO_ERR_DROP_EN
  assign push_req = i_rx_complete & ~i_rx_error;
`else
  assign push_req = i_rx_complete;
`endif

  // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
  assign pop     = i_rd_en & ~empty_q;
  assign push    = push_req & (~full_q | pop);
  assign ovf_evt = push_req & full_q & ~pop;
  assign err_evt = i_rx_complete & i_rx_error;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    count_d  = wr_ptr_d - rd_ptr_d;

    ovf_d = ovf_q;
    if (ovf_evt)         ovf_d = 1'b1;
    else if (i_clr_stat) ovf_d = 1'b0;

    err_cnt_d = err_cnt_q;
    if (err_evt) begin
      if (i_clr_stat)                             err_cnt_d = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      else if (err_cnt_q != {ERR_CNT_W{1'b1}})    err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end else if (i_clr_stat) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  uart_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (push),
    .i_waddr (wr_ptr_q[AW-1:0]),
    .i_wd    (i_rx_d),
    .i_raddr (rd_ptr_q[AW-1:0]),
    .o_rd    (o_rd_d)
  );

  assign o_empty    = empty_q;
  assign o_full     = full_q;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;
  assign o_err_cnt  = err_cnt_q;

endmodule
